// File: rtl/dtcctf_trgunit.sv
// Multi-channel DTC/CTF trigger front end: synchronise, mask, combine, and shape triggers with hold-off.
// Optional accepted/lost counters are built only when DTCCTF_TRGCNT_EN is defined.
module dtcctf_trgunit #(
  parameter int unsigned N_CH      = 2,
  parameter int unsigned HOLDOFF_W = 8,
  parameter int unsigned PULSE_W   = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk0,
  input  logic                 rst,
  input  logic [N_CH-1:0]      trg_in,
  input  logic                 clk_ok,
  input  logic [N_CH-1:0]      cfg_invert,
  input  logic [N_CH-1:0]      cfg_enable,
  input  logic                 cfg_mode,
  input  logic [3:0]           cfg_sel,
  input  logic [PULSE_W-1:0]   cfg_pulse,
  input  logic [HOLDOFF_W-1:0] cfg_holdoff,
  input  logic                 cnt_clr,
  output logic                 trg_out,
  output logic                 trg_busy,
  output logic [CNT_W-1:0]     trg_count,
  output logic [CNT_W-1:0]     trg_lost
);

  localparam int unsigned TW = (PULSE_W > HOLDOFF_W) ? PULSE_W : HOLDOFF_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PULSE = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [N_CH-1:0]      sync1;
  logic [N_CH-1:0]      sync2;
  logic [N_CH-1:0]      masked;
  logic                 sel_lvl;
  logic                 lvl;
  logic                 lvl_prev;
  logic                 evt;
  logic [1:0]           arm_cnt;
  logic                 armed;

  logic [1:0]           state;
  logic [1:0]           state_nxt;
  logic [TW-1:0]        tmr;
  logic [TW-1:0]        tmr_nxt;
  logic [HOLDOFF_W-1:0] hold_len;
  logic [HOLDOFF_W-1:0] hold_nxt;
  logic                 count_inc;
  logic                 lost_inc;

  // Two-flop synchroniser per channel
  always_ff @(posedge clk0) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= trg_in;
      sync2 <= sync1;
    end
  end

  assign masked = (sync2 ^ cfg_invert) & cfg_enable;

  // Out-of-range select leaves sel_lvl at 0
  always_comb begin
    sel_lvl = 1'b0;
    for (int i = 0; i < int'(N_CH); i++) begin
      if (cfg_sel == 4'(i)) sel_lvl = masked[i];
    end
  end

  assign lvl   = cfg_mode ? sel_lvl : (|masked);
  assign armed = (arm_cnt == 2'd3);

  // Arming hides the synthetic edge of a level that was already high during reset
  always_ff @(posedge clk0) begin
    if (rst) begin
      arm_cnt  <= 2'd0;
      lvl_prev <= 1'b0;
      evt      <= 1'b0;
    end else begin
      if (!armed) arm_cnt <= arm_cnt + 2'd1;
      lvl_prev <= lvl;
      evt      <= lvl & ~lvl_prev & armed;
    end
  end

  always_ff @(posedge clk0) begin
    if (rst) begin
      state    <= S_IDLE;
      tmr      <= '0;
      hold_len <= '0;
      trg_out  <= 1'b0;
      trg_busy <= 1'b0;
    end else begin
      state    <= state_nxt;
      tmr      <= tmr_nxt;
      hold_len <= hold_nxt;
      trg_out  <= (state_nxt == S_PULSE);
      trg_busy <= (state_nxt != S_IDLE);
    end
  end

  // Pulse/hold-off sequencing; lengths are captured when a pulse starts
  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    hold_nxt  = hold_len;
    count_inc = 1'b0;
    lost_inc  = 1'b0;
    case (state)
      S_IDLE: begin
        if (evt) begin
          if (clk_ok) begin
            state_nxt = S_PULSE;
            tmr_nxt   = (cfg_pulse == '0) ? TW'(1) : TW'(cfg_pulse);
            hold_nxt  = cfg_holdoff;
            count_inc = 1'b1;
          end else begin
            lost_inc = 1'b1;
          end
        end
      end
      S_PULSE: begin
        lost_inc = evt;
        if (!clk_ok) begin
          state_nxt = S_IDLE;
        end else if (tmr == TW'(1)) begin
          if (hold_len != '0) begin
            state_nxt = S_HOLD;
            tmr_nxt   = TW'(hold_len);
          end else begin
            state_nxt = S_IDLE;
          end
        end else begin
          tmr_nxt = tmr - TW'(1);
        end
      end
      S_HOLD: begin
        lost_inc = evt;
        if (!clk_ok || (tmr == TW'(1))) begin
          state_nxt = S_IDLE;
        end else begin
          tmr_nxt = tmr - TW'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

`ifdef DTCCTF_TRGCNT_EN
  // Saturating counters; clear wins over a coincident increment
  always_ff @(posedge clk0) begin
    if (rst || cnt_clr) begin
      trg_count <= '0;
      trg_lost  <= '0;
    end else begin
      if (count_inc && !(&trg_count)) trg_count <= trg_count + CNT_W'(1);
      if (lost_inc && !(&trg_lost))   trg_lost  <= trg_lost + CNT_W'(1);
    end
  end
`else
  logic unused_cnt;
  assign unused_cnt = ^{cnt_clr, count_inc, lost_inc};
  assign trg_count  = '0;
  assign trg_lost   = '0;
`endif

endmodule

// File: tb/tb_dtcctf_trgunit.sv
// Directed self-checking bench for dtcctf_trgunit (N_CH=2, CNT_W=4 so saturation is reachable).
module tb_dtcctf_trgunit;

`ifdef DTCCTF_TRGCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk0;
  logic       rst;
  logic [1:0] trg_in;
  logic       clk_ok;
  logic [1:0] cfg_invert;
  logic [1:0] cfg_enable;
  logic       cfg_mode;
  logic [3:0] cfg_sel;
  logic [3:0] cfg_pulse;
  logic [7:0] cfg_holdoff;
  logic       cnt_clr;
  logic       trg_out;
  logic       trg_busy;
  logic [3:0] trg_count;
  logic [3:0] trg_lost;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] w;
  logic [31:0] b;
  logic        seen;

  dtcctf_trgunit #(
    .N_CH(2), .HOLDOFF_W(8), .PULSE_W(4), .CNT_W(4)
  ) dut (
    .clk0(clk0), .rst(rst), .trg_in(trg_in), .clk_ok(clk_ok),
    .cfg_invert(cfg_invert), .cfg_enable(cfg_enable), .cfg_mode(cfg_mode),
    .cfg_sel(cfg_sel), .cfg_pulse(cfg_pulse), .cfg_holdoff(cfg_holdoff),
    .cnt_clr(cnt_clr), .trg_out(trg_out), .trg_busy(trg_busy),
    .trg_count(trg_count), .trg_lost(trg_lost)
  );

  initial clk0 = 1'b0;
  always #5 clk0 = ~clk0;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  function automatic logic [31:0] ce(input int n);
    return CNT_EN ? 32'(n) : 32'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk0);
      #1;
    end
  endtask

  // Bit k of each pattern is driven before edge k; bit k of ow/ob is sampled after edge k
  task automatic run(input logic [31:0] p0, input logic [31:0] p1, input logic [31:0] pk,
                     output logic [31:0] ow, output logic [31:0] ob);
    for (int k = 0; k < 32; k++) begin
      trg_in = {p1[k], p0[k]};
      clk_ok = pk[k];
      @(posedge clk0);
      #1;
      ow[k] = trg_out;
      ob[k] = trg_busy;
    end
  endtask

  initial begin
    rst = 1'b1; trg_in = 2'b01; clk_ok = 1'b1;
    cfg_invert = 2'b00; cfg_enable = 2'b01; cfg_mode = 1'b0; cfg_sel = 4'd0;
    cfg_pulse = 4'd3; cfg_holdoff = 8'd0; cnt_clr = 1'b0;
    step(3);
    chk("rst_out",   32'(trg_out),   32'd0);
    chk("rst_busy",  32'(trg_busy),  32'd0);
    chk("rst_count", 32'(trg_count), 32'd0);
    chk("rst_lost",  32'(trg_lost),  32'd0);

    // Level held high through reset must not trigger
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      seen = seen | trg_out;
    end
    chk("held_hi_out",   32'(seen),      32'd0);
    chk("held_hi_count", 32'(trg_count), 32'd0);
    trg_in = 2'b00;
    step(6);

    // Single edge, pulse 3, no hold-off
    run(32'h7, 32'h0, 32'hFFFF_FFFF, w, b);
    chk("p3_wave",  w, 32'h38);
    chk("p3_busy",  b, 32'h38);
    chk("p3_count", 32'(trg_count), ce(1));
    chk("p3_lost",  32'(trg_lost),  ce(0));

    // Pulse 2, hold-off 5: edges at 0 (ok), 4 (lost), 12 (ok)
    cfg_pulse = 4'd2; cfg_holdoff = 8'd5;
    run(32'h3033, 32'h0, 32'hFFFF_FFFF, w, b);
    chk("ho_wave",  w, 32'h18018);
    chk("ho_busy",  b, 32'h3F83F8);
    chk("ho_count", 32'(trg_count), ce(3));
    chk("ho_lost",  32'(trg_lost),  ce(1));

    // Select mode, ch1 inverted: falling ch1 triggers, rising ch0 ignored
    cfg_holdoff = 8'd0;
    trg_in = 2'b10;
    step(4);
    cfg_invert = 2'b10; cfg_enable = 2'b11; cfg_mode = 1'b1; cfg_sel = 4'd1;
    step(4);
    run(32'h700, 32'h0, 32'hFFFF_FFFF, w, b);
    chk("sel1_wave",  w, 32'h18);
    chk("sel1_count", 32'(trg_count), ce(4));
    cfg_sel = 4'd5;
    step(2);
    run(32'h7000, 32'h70, 32'hFFFF_FFFF, w, b);
    chk("sel5_wave", w, 32'h0);
    cfg_mode = 1'b0; cfg_invert = 2'b00; cfg_enable = 2'b01; cfg_sel = 4'd0;
    step(4);

    // Edge while clock not ok
    run(32'h7, 32'h0, 32'h0, w, b);
    chk("cko_wave", w, 32'h0);
    chk("cko_lost", 32'(trg_lost), ce(2));
    clk_ok = 1'b1;
    step(4);

    // clk_ok drops at edge 5 during an 8-cycle pulse
    cfg_pulse = 4'd8;
    run(32'h7, 32'h0, 32'h1F, w, b);
    chk("abort_wave",  w, 32'h18);
    chk("abort_busy",  b, 32'h18);
    chk("abort_count", 32'(trg_count), ce(5));
    clk_ok = 1'b1;
    step(4);

    cnt_clr = 1'b1;
    step(1);
    cnt_clr = 1'b0;
    chk("clr_count", 32'(trg_count), 32'd0);
    chk("clr_lost",  32'(trg_lost),  32'd0);

    // cfg_pulse 0 behaves as 1
    cfg_pulse = 4'd0;
    run(32'h7, 32'h0, 32'hFFFF_FFFF, w, b);
    chk("p0_wave", w, 32'h8);
    for (int i = 0; i < 16; i++) begin
      trg_in = 2'b01;
      step(3);
      trg_in = 2'b00;
      step(5);
    end
    chk("sat_count", 32'(trg_count), ce(15));
    chk("sat_lost",  32'(trg_lost),  ce(0));

    // cnt_clr coincides with an accepted event
    cfg_pulse = 4'd3;
    trg_in = 2'b01;
    step(3);
    cnt_clr = 1'b1;
    step(1);
    cnt_clr = 1'b0;
    chk("clrhit_out",   32'(trg_out),   32'd1);
    chk("clrhit_count", 32'(trg_count), 32'd0);
    trg_in = 2'b00;
    step(8);

    // Reset in the middle of a pulse
    cfg_pulse = 4'd8;
    trg_in = 2'b01;
    step(5);
    chk("mid_pre_out",   32'(trg_out),   32'd1);
    chk("mid_pre_count", 32'(trg_count), ce(1));
    rst = 1'b1;
    trg_in = 2'b00;
    step(1);
    chk("mid_rst_out",   32'(trg_out),   32'd0);
    chk("mid_rst_busy",  32'(trg_busy),  32'd0);
    chk("mid_rst_count", 32'(trg_count), 32'd0);
    rst = 1'b0;
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dtcctf_trgunit.md
# dtcctf_trgunit

Parametrised multi-channel DTC trigger front end, the next generation of the DTC/CTF trigger path. It takes N asynchronous trigger lines from the DTC/CTF PHY layer and synchronises each to clk0. Per channel it applies inversion and enable masks and combines the channels by OR or by single-channel select. It emits a clean trigger pulse of programmable width, followed by a programmable hold-off, gated by the DTC clock-ok status, and reports accepted and lost trigger counts to slow control.

## Interface
- N_CH, 2: number of trigger input channels (1..16)
- HOLDOFF_W, 8: width of hold-off counter/config
- PULSE_W, 4: width of pulse-length counter/config
- CNT_W, 16: width of accepted/lost trigger counters
- clk0  in  1  system clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- trg_in  in  N_CH  asynchronous trigger lines from DTC PHY
- clk_ok  in  1  DTC clock valid (from clock unit); triggers accepted only when high
- cfg_invert  in  N_CH  per-channel polarity invert, applied after synchroniser
- cfg_enable  in  N_CH  per-channel enable; disabled channel contributes 0
- cfg_mode  in  1  0 = OR of enabled channels, 1 = select channel cfg_sel only
- cfg_sel  in  4  channel index for cfg_mode=1; index >= N_CH selects nothing
- cfg_pulse  in  PULSE_W  trg_out high time in cycles; 0 treated as 1
- cfg_holdoff  in  HOLDOFF_W  dead cycles after pulse; 0 = none
- cnt_clr  in  1  synchronous clear of trg_count and trg_lost
- trg_out  out  1  registered trigger pulse
- trg_busy  out  1  high in PULSE and HOLDOFF states
- trg_count  out  CNT_W  accepted triggers, saturating
- trg_lost  out  CNT_W  rejected rising edges, saturating

## Operation
- Per channel: 2-flop synchroniser, then XOR cfg_invert, AND cfg_enable, giving the combined level `lvl` per cfg_mode.
- Event = rising edge of `lvl`, using one previous-value register.
- Arming: after rst deasserts, events are ignored for the first 3 cycles. A level held high through reset produces no trigger.
- FSM IDLE:
  - event and clk_ok go to PULSE: load pulse counter with max(cfg_pulse,1) and increment trg_count.
  - event with clk_ok low increments trg_lost and stays in IDLE.
- FSM PULSE: trg_out=1. Decrement the counter each cycle. At count 1, go to HOLDOFF if cfg_holdoff != 0, otherwise IDLE.
- FSM HOLDOFF: trg_out=0. Count down cfg_holdoff cycles, then go to IDLE.
- Events in PULSE or HOLDOFF are not retriggered; each increments trg_lost.
- clk_ok falling in PULSE or HOLDOFF: abort to IDLE at the next edge, with trg_out low from that edge.
- cfg_* are sampled only when a pulse starts (pulse/hold-off lengths) or continuously (masks/mode); a mask change can create an edge, and that edge is legal.
- Counters saturate at all-ones; no wrap.
- cnt_clr has priority: when an event coincides with cnt_clr, the affected counter reads 0 after the edge.

## Timing
- Reset values: trg_out=0, trg_busy=0, trg_count=0, trg_lost=0. Synchroniser and previous-value register are 0 and state is IDLE.
- Latency: trg_in first sampled high at edge E gives trg_out high after edge E+3. Stages: sync1, sync2, edge register, output register.
- trg_out is high for exactly max(cfg_pulse,1) cycles.
- The earliest next accepted event comes max(cfg_pulse,1)+cfg_holdoff cycles after trg_out rises.
- trg_count updates at the same edge that trg_out rises.
- trg_lost updates 1 cycle after the rejected event is detected at the edge register.
- trg_busy is asserted from the same edge as trg_out and deasserts on return to IDLE.
- rst mid-pulse: trg_out and trg_busy are 0 after the reset edge and counters clear.
- Input pulses shorter than 2 clk0 periods may be missed; this is not a requirement.

## Configuration
- DTCCTF_TRGCNT_EN defined: trg_count/trg_lost counters and cnt_clr are implemented as above.
- DTCCTF_TRGCNT_EN not defined: the counters are not built, trg_count and trg_lost are tied to 0, and cnt_clr is ignored. FSM, trg_out and trg_busy behaviour is identical.

## Test plan
- Reset with trg_in[0] held high, cfg_enable=01, mode 0: no trg_out after reset release and trg_count=0.
- cfg_pulse=3, cfg_holdoff=0, single edge on ch0 at E: trg_out high after edges E+3..E+5, low at E+6, trg_count=1.
- cfg_pulse=2, cfg_holdoff=5, second edge 4 cycles after the first: second edge rejected with trg_lost=1; third edge after 8 cycles accepted with trg_count=2.
- mode 1, cfg_sel=1, cfg_invert=10, falling edge on ch1 and rising edge on ch0: exactly one trigger (ch1); cfg_sel=5 with N_CH=2 gives no triggers.
- clk_ok=0 with an edge: no trg_out and trg_lost=1. Drop clk_ok during a cfg_pulse=8 pulse: trg_out low by the next edge and state back in IDLE.
- Preload with CNT_W=4 and 17 accepted events: trg_count=15 (saturated). cnt_clr coinciding with an accepted event: trg_count=0 while trg_out still pulses. Build without DTCCTF_TRGCNT_EN: counters read 0.
